dus_hls_host: RTL and testbench

Host-side counterpart of the `dus_hls` kernel wrapper. It owns the two single-port RAMs the kernel accesses through its `ap_memory` ports: `img` is the input image and `dus` is the result. It also drives the kernel's `ap_ctrl_hs` start handshake. A transfer runs in three steps: stream DEPTH words into `img`, run the kernel once, then stream DEPTH words out of `dus`.

---
 rtl/dus_hls_host_if.sv | 54 +++++
 rtl/dus_hls_host.sv | 235 +++++++++++++++++++++++
 tb/tb_dus_hls_host.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dus_hls_host_if.sv
// -----------------------------------------------------------------------------
// dus_hls_host_if
// Bundles the signals between dus_hls_host and its surroundings: the load and
// drain streams, the kernel ap_ctrl_hs handshake, and the kernel's ap_memory
// ports into the img and dus RAMs.
//   master : the host block (drives in_ready, out_*, ap_start, *_q0)
//   slave  : the environment (stream source/sink and the kernel)
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface dus_hls_host_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;

    logic          img_ce0;
    logic          img_we0;
    logic [AW-1:0] img_address0;
    logic [DW-1:0] img_d0;
    logic [DW-1:0] img_q0;

    logic          dus_ce0;
    logic          dus_we0;
    logic [AW-1:0] dus_address0;
    logic [DW-1:0] dus_d0;
    logic [DW-1:0] dus_q0;

    modport master (
        input  in_valid, in_data, output in_ready,
        output out_valid, out_data, input out_ready,
        output ap_start, input ap_ready, ap_done, ap_idle,
        input  img_ce0, img_we0, img_address0, img_d0, output img_q0,
        input  dus_ce0, dus_we0, dus_address0, dus_d0, output dus_q0
    );

    modport slave (
        output in_valid, in_data, input in_ready,
        input  out_valid, out_data, output out_ready,
        input  ap_start, output ap_ready, ap_done, ap_idle,
        output img_ce0, img_we0, img_address0, img_d0, input img_q0,
        output dus_ce0, dus_we0, dus_address0, dus_d0, input dus_q0
    );
endinterface

// File: rtl/dus_hls_host.sv
// -----------------------------------------------------------------------------
// dus_hls_host
// Host side of the dus_hls kernel: owns the img (input) and dus (result)
// single-port RAMs and sequences one transfer per go pulse: stream DEPTH words
// into img, start the kernel and wait for it, stream DEPTH words out of dus.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   go         transfer start pulse, honoured in IDLE only
//   busy       high whenever the FSM is not IDLE
//   run_cycles START+RUN cycle count (only with DUS_HOST_PERF_EN)
//   bus        dus_hls_host_if.master: load/drain streams, ap_ctrl_hs,
//              kernel ap_memory ports for img and dus
// Optional feature macro: DUS_HOST_PERF_EN (adds run_cycles).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for go
// ST_LOAD  | accepting load-stream words into img[0..DEPTH-1]
// ST_START | ap_start high, waiting for ap_ready
// ST_RUN   | kernel running, waiting for ap_done
// ST_DRAIN | streaming dus[0..DEPTH-1] out
// -----------------------------------------------------------------------------
module dus_hls_host #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        busy,
`ifdef DUS_HOST_PERF_EN
    output logic [31:0] run_cycles,
`endif
    dus_hls_host_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] load_cnt_q, load_cnt_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] out_cnt_q, out_cnt_d;
    logic          s1_vld_q, s1_vld_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] img_rdata_q, img_rdata_d;
    logic [DW-1:0] dus_rdata_q, dus_rdata_d;

    logic [DW-1:0] img_mem [DEPTH];
    logic [DW-1:0] dus_mem [DEPTH];

    logic          kern_phase;
    logic          load_fire;
    logic          out_fire;
    logic          out_load;
    logic          rd_issue;
    logic          img_in_rng;
    logic          dus_in_rng;
    logic          rd_in_rng;
    logic          img_we;
    logic [AW-1:0] img_waddr;
    logic [DW-1:0] img_wdata;
    logic          dus_we;

    logic          unused_ap_idle;
    assign unused_ap_idle = bus.ap_idle;

    assign kern_phase = (state_q == ST_START) || (state_q == ST_RUN);
    assign load_fire  = (state_q == ST_LOAD) && bus.in_valid;
    assign img_in_rng = 32'(bus.img_address0) < DEPTH;
    assign dus_in_rng = 32'(bus.dus_address0) < DEPTH;
    assign rd_in_rng  = 32'(rd_ptr_q) < DEPTH;

    // Drain pipeline: read issue -> dus_rdata_q (s1) -> out_data_q.
    // A new read is issued only when s1 is empty or moving on this cycle, and
    // dus_rdata_q only updates on a read, so a stalled word is never lost.
    assign out_fire  = out_valid_q && bus.out_ready;
    assign out_load  = s1_vld_q && (!out_valid_q || bus.out_ready);
    assign rd_issue  = (state_q == ST_DRAIN) && rd_in_rng && (!s1_vld_q || out_load);

    // Single port per RAM: the host owns img in LOAD and dus in DRAIN, the
    // kernel owns both in START/RUN.
    always_comb begin
        img_we    = 1'b0;
        img_waddr = bus.img_address0;
        img_wdata = bus.img_d0;
        if (load_fire) begin
            img_we    = 1'b1;
            img_waddr = load_cnt_q;
            img_wdata = bus.in_data;
        end else if (kern_phase && bus.img_ce0 && bus.img_we0 && img_in_rng) begin
            img_we = 1'b1;
        end
        dus_we = kern_phase && bus.dus_ce0 && bus.dus_we0 && dus_in_rng;

        img_rdata_d = img_rdata_q;
        if (kern_phase && bus.img_ce0 && !bus.img_we0) begin
            img_rdata_d = img_in_rng ? img_mem[bus.img_address0] : '0;
        end

        // One read register serves both kernel reads and host prefetch.
        dus_rdata_d = dus_rdata_q;
        if (rd_issue) begin
            dus_rdata_d = dus_mem[rd_ptr_q[AW-1:0]];
        end else if (kern_phase && bus.dus_ce0 && !bus.dus_we0) begin
            dus_rdata_d = dus_in_rng ? dus_mem[bus.dus_address0] : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_cnt_d   = out_cnt_q;
        s1_vld_d    = s1_vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                load_cnt_d = '0;
                if (go) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_fire) begin
                    if (32'(load_cnt_q) == DEPTH - 1) begin
                        load_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        load_cnt_d = load_cnt_q + AW'(1);
                    end
                end
            end
            ST_START: begin
                if (bus.ap_ready) state_d = bus.ap_done ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (bus.ap_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire && (32'(out_cnt_q) == DEPTH - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_DRAIN) begin
            rd_ptr_d    = '0;
            out_cnt_d   = '0;
            s1_vld_d    = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                s1_vld_d = 1'b1;
            end else if (out_load) begin
                s1_vld_d = 1'b0;
            end
            if (out_load) begin
                out_valid_d = 1'b1;
                out_data_d  = dus_rdata_q;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end
            if (out_fire) out_cnt_d = out_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            out_cnt_q   <= '0;
            s1_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            img_rdata_q <= '0;
            dus_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_cnt_q   <= out_cnt_d;
            s1_vld_q    <= s1_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            img_rdata_q <= img_rdata_d;
            dus_rdata_q <= dus_rdata_d;
        end
    end

    // RAM arrays are not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && img_we) img_mem[img_waddr] <= img_wdata;
        if (rst && dus_we) dus_mem[bus.dus_address0] <= bus.dus_d0;
    end

`ifdef DUS_HOST_PERF_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if ((state_q == ST_LOAD) && (state_d == ST_START)) begin
            run_cycles_d = '0;
        end else if (kern_phase) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) run_cycles_q <= '0;
        else      run_cycles_q <= run_cycles_d;
    end

    assign run_cycles = run_cycles_q;
`endif

    assign busy          = (state_q != ST_IDLE);
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.ap_start  = (state_q == ST_START);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    // Kernel read data is only visible while the kernel owns the RAMs.
    assign bus.img_q0    = kern_phase ? img_rdata_q : '0;
    assign bus.dus_q0    = kern_phase ? dus_rdata_q : '0;

endmodule

// File: tb/tb_dus_hls_host.sv
// -----------------------------------------------------------------------------
// tb_dus_hls_host
// Directed bench for dus_hls_host with DEPTH=1024. A scenario table drives
// whole transfers (load pattern, ap_ready delay, same-cycle ready/done, drain
// backpressure, fixed-length run) with hand-computed expectations; hand-written
// sequences cover reset values, idle kernel accesses and a mid-run reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dus_hls_host;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go  = 1'b0;
    logic busy;
`ifdef DUS_HOST_PERF_EN
    logic [31:0] run_cycles;
`endif

    dus_hls_host_if #(.AW(AW), .DW(DW)) bus ();

    dus_hls_host #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .busy       (busy),
`ifdef DUS_HOST_PERF_EN
        .run_cycles (run_cycles),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned mult;        // load word i = mult*i + off
        int unsigned off;
        int          ready_delay; // START cycles with ap_ready low
        bit          same_cycle;  // ap_done together with ap_ready
        int          done_after;  // 0: copy kernel (DEPTH+2 RUN cycles), else RUN length
        bit          bp;          // random out_ready
        bit          idle_poke;   // kernel accesses in IDLE before go
        int          exp_start;   // expected cycles with ap_start high
        int          exp_run;     // expected run_cycles
    } row_t;

    row_t        rows [5];
    logic [31:0] exp_dus [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] img_val(input row_t r, input int i);
        return 32'(r.mult * i + r.off);
    endfunction

    task automatic clear_kernel_ports();
        bus.img_ce0 = 1'b0; bus.img_we0 = 1'b0; bus.img_address0 = '0; bus.img_d0 = '0;
        bus.dus_ce0 = 1'b0; bus.dus_we0 = 1'b0; bus.dus_address0 = '0; bus.dus_d0 = '0;
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    // Kernel accesses while IDLE must neither write nor return data.
    task automatic idle_poke();
        @(negedge clk);
        bus.dus_ce0 = 1'b1; bus.dus_we0 = 1'b1; bus.dus_address0 = '0; bus.dus_d0 = 32'hDEAD_BEEF;
        bus.img_ce0 = 1'b1; bus.img_we0 = 1'b0; bus.img_address0 = 10'd3;
        @(negedge clk);
        check("idle_img_q0", bus.img_q0, 32'd0);
        bus.img_ce0 = 1'b0;
        bus.dus_we0 = 1'b0; bus.dus_address0 = 10'd1;
        @(negedge clk);
        check("idle_dus_q0", bus.dus_q0, 32'd0);
        clear_kernel_ports();
    endtask

    // Entered at the first LOAD cycle; returns at the first START cycle.
    task automatic do_load(input row_t r);
        int i = 0;
        int c = 0;
        while (i < DEPTH && c < 4 * DEPTH) begin
            if (c > 0) @(negedge clk);
            if (c == 0) check("load_entry_in_ready", 32'(bus.in_ready), 32'd1);
            go = (c == 100);
            bus.in_valid = (c % 9 != 4);
            bus.in_data  = img_val(r, i);
            if (bus.in_valid && bus.in_ready) i++;
            c++;
        end
        @(negedge clk);
        go = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        check("load_words", 32'(i), 32'(DEPTH));
    endtask

    // Entered at the first START cycle; returns at the first DRAIN cycle.
    task automatic do_kernel(input row_t r);
        int cnt = 0;
        int g = 0;
        int run_len;
        check("start_rise", 32'(bus.ap_start), 32'd1);
        while (bus.ap_start && g < 64) begin
            cnt++;
            bus.ap_ready = (cnt > r.ready_delay);
            bus.ap_done  = r.same_cycle && bus.ap_ready;
            @(negedge clk);
            g++;
        end
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        check("start_cycles", 32'(cnt), 32'(r.exp_start));
        if (!r.same_cycle) begin
            run_len = (r.done_after > 0) ? r.done_after : DEPTH + 2;
            for (int rc = 1; rc <= run_len; rc++) begin
                int k;
                if (rc > 1) @(negedge clk);
                k = rc - 1;
                if (r.done_after == 0) begin
                    if (k >= 1 && k <= DEPTH) begin
                        bus.dus_ce0 = 1'b1; bus.dus_we0 = 1'b1;
                        bus.dus_address0 = AW'(k - 1);
                        bus.dus_d0 = bus.img_q0 + 32'd1;
                        exp_dus[k-1] = img_val(r, k - 1) + 32'd1;
                    end else begin
                        bus.dus_ce0 = 1'b0; bus.dus_we0 = 1'b0;
                    end
                    if (k < DEPTH) begin
                        bus.img_ce0 = 1'b1; bus.img_we0 = 1'b0;
                        bus.img_address0 = AW'(k);
                    end else begin
                        bus.img_ce0 = 1'b0;
                    end
                end
                bus.ap_done = (rc == run_len);
            end
            @(negedge clk);
            bus.ap_done = 1'b0;
            clear_kernel_ports();
        end
`ifdef DUS_HOST_PERF_EN
        check("run_cycles_at_drain", run_cycles, 32'(r.exp_run));
`endif
    endtask

    // Entered at the first DRAIN cycle; returns one cycle after the last word.
    task automatic do_drain(input row_t r);
        int          got = 0;
        int          c = 0;
        int          first = -1;
        int          bad = 0;
        int          bad_idx = -1;
        int          stall_bad = 0;
        bit          prev_stall = 1'b0;
        bit          rdy;
        logic [31:0] prev = '0;
        logic [31:0] bad_act = '0;
        while (got < DEPTH && c < 6 * DEPTH) begin
            if (c > 0) @(negedge clk);
            rdy = r.bp ? ($urandom_range(0, 1) != 0) : 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid && first < 0) first = c;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev)) stall_bad++;
            if (bus.out_valid && rdy) begin
                if (bus.out_data !== exp_dus[got]) begin
                    if (bad == 0) begin
                        bad_idx = got;
                        bad_act = bus.out_data;
                    end
                    bad++;
                end
                got++;
            end
            prev_stall = bus.out_valid && !rdy;
            prev = bus.out_data;
            c++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_first_valid_cycle", 32'(first), 32'd2);
        check("drain_words", 32'(got), 32'(DEPTH));
        if (bad != 0) $display("  first wrong word %0d: 0x%0h vs 0x%0h", bad_idx, bad_act, exp_dus[bad_idx]);
        check("drain_wrong_words", 32'(bad), 32'd0);
        check("drain_stall_changes", 32'(stall_bad), 32'd0);
        check("busy_after_drain", 32'(busy), 32'd0);
        check("out_valid_after_drain", 32'(bus.out_valid), 32'd0);
`ifdef DUS_HOST_PERF_EN
        check("run_cycles_hold", run_cycles, 32'(r.exp_run));
`endif
    endtask

    task automatic do_transfer(input row_t r);
        if (r.idle_poke) idle_poke();
        pulse_go();
        do_load(r);
        do_kernel(r);
        do_drain(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mult off dly same done bp  poke start run
        rows[0] = '{1, 0,  0, 1'b0, 0,   1'b0, 1'b0, 1, 1027}; // out 1..1024
        rows[1] = '{3, 0,  5, 1'b0, 0,   1'b0, 1'b0, 6, 1032}; // ap_ready held low 5 cycles
        rows[2] = '{7, 5,  0, 1'b1, 0,   1'b0, 1'b1, 1, 1};    // same-cycle ready/done, dus from row 1
        rows[3] = '{5, 9,  2, 1'b0, 0,   1'b1, 1'b0, 3, 1029}; // random out_ready
        rows[4] = '{2, 1,  0, 1'b0, 100, 1'b0, 1'b0, 1, 101};  // done 100 cycles after ready
        for (int i = 0; i < DEPTH; i++) exp_dus[i] = '0;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.ap_ready = 1'b0; bus.ap_done = 1'b0; bus.ap_idle = 1'b1;
        clear_kernel_ports();

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ap_start",  32'(bus.ap_start),  32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_img_q0",    bus.img_q0,         32'd0);
        check("rst_dus_q0",    bus.dus_q0,         32'd0);
`ifdef DUS_HOST_PERF_EN
        check("rst_run_cycles", run_cycles, 32'd0);
`endif
        rst = 1'b1;

        for (int t = 0; t < 5; t++) do_transfer(rows[t]);

        // Reset for one cycle in the middle of RUN, then a fresh transfer.
        pulse_go();
        do_load(rows[0]);
        check("mrr_ap_start", 32'(bus.ap_start), 32'd1);
        bus.ap_ready = 1'b1;
        @(negedge clk);
        bus.ap_ready = 1'b0;
        check("mrr_run_ap_start", 32'(bus.ap_start), 32'd0);
        check("mrr_run_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mrr_busy", 32'(busy), 32'd0);
        check("mrr_ap_start_low", 32'(bus.ap_start), 32'd0);
        check("mrr_in_ready", 32'(bus.in_ready), 32'd0);
        pulse_go();
        check("mrr_go_busy", 32'(busy), 32'd1);
        do_load(rows[0]);
        do_kernel(rows[0]);
        do_drain(rows[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
